mult_div_unit: RTL and testbench

- Sequential signed multiply/divide unit that sits directly downstream of the ALU source-B mux, in parallel with the ALU.
- Operand A comes from the register-A output; operand B comes from the ALU source-B mux output.
- Executes MIPS-style mult/div over many cycles and holds the results in HI/LO registers, which are read by mfhi/mflo.
- Controlled by the multicycle control unit through a start/busy/done handshake.

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with HI/LO result registers.
// Shift-add multiply or restoring divide over WIDTH cycles, then one sign-fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_fits;
  logic               w_b_zero;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH-1:0]   w_quo_signed;
  logic [WIDTH-1:0]   w_rem_signed;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (r_count == LAST_ITER) w_next = S_SIGN;
      end
      S_SIGN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Two's-complement negate of INT_MIN yields INT_MIN, which is the correct unsigned magnitude.
  assign w_abs_a = opA[WIDTH-1] ? -opA : opA;
  assign w_abs_b = opB[WIDTH-1] ? -opB : opB;

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_mag_b[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});

  // Divide: shift in the next dividend bit; a non-negative trial difference means the divisor fits.
  assign w_div_trial = {r_rem[WIDTH-1:0], r_mag_a[WIDTH-1]};
  assign w_div_diff  = w_div_trial - {1'b0, r_mag_b};
  assign w_div_fits  = ~w_div_diff[WIDTH];
  assign w_b_zero    = (r_mag_b == '0);

  assign w_prod_signed = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo_signed  = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
  assign w_rem_signed  = r_sign_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op       <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= (r_state == S_SIGN) && r_op && w_b_zero;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= opA[WIDTH-1];
            r_sign_b <= opB[WIDTH-1];
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          r_count <= r_count + 1'b1;
          if (!r_op) begin
            r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_mag_b <= r_mag_b >> 1;
          end else begin
            r_rem   <= w_div_fits ? w_div_diff : w_div_trial;
            r_quo   <= {r_quo[WIDTH-2:0], w_div_fits};
            r_mag_a <= r_mag_a << 1;
          end
        end
        S_SIGN: begin
          if (!r_op) begin
            r_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_signed[WIDTH-1:0];
          end else if (!w_b_zero) begin
            r_hi <= w_rem_signed;
            r_lo <= w_quo_signed;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign divZero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed results, divide by zero,
// extremes, ignored start while busy, and reset in the middle of an operation.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one operation, scrambles the operand inputs mid-run, and checks timing and results.
  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    int  cyc;
    int  busy_cyc;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_cyc = 0;
    seen     = 1'b0;
    while (cyc <= 100 && !seen) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) busy_cyc++;
        if (cyc == 5) begin
          opA = ~a;
          opB = a ^ b ^ 32'h5A5A_0F0F;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " busy cycles"}, 32'(busy_cyc), 32'd33);
    check({tag, " done cycle"}, 32'(cyc), 32'd34);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " divZero"}, 32'(divZero), 32'(exp_dz));
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(done), 32'd0);
    check({tag, " divZero pulse width"}, 32'(divZero), 32'd0);
    check({tag, " hi held"}, hi, exp_hi);
  endtask

  initial begin
    int n_done;

    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset divZero", 32'(divZero), 32'd0);

    run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    // 1682 / 32 = 52 rem 18 leaves hi=0x12, lo=0x34 for the divide-by-zero hold check.
    run_op("div 1682/32", 1'b1, 32'd1682, 32'd32, 32'h0000_0012, 32'h0000_0034, 1'b0);
    run_op("div 100/0", 1'b1, 32'd100, 32'd0, 32'h0000_0012, 32'h0000_0034, 1'b1);

    run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // A second start pulse at cycle 10 must be ignored: exactly one done, result of the first op.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    opA   = 32'd5;
    opB   = 32'd6;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 80; c++) begin
      if (done === 1'b1) n_done++;
      if (c == 10) begin
        start = 1'b1;
        op    = 1'b1;
        opA   = 32'd99;
        opB   = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy start done count", 32'(n_done), 32'd1);
    check("busy start hi", hi, 32'h0);
    check("busy start lo", lo, 32'd30);

    // Reset asserted at cycle 20 of a divide: idle next cycle, registers cleared, no done.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    opA   = 32'd1000;
    opB   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid-op busy before reset", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset done", 32'(done), 32'd0);
    check("mid-op reset hi", hi, 32'h0);
    check("mid-op reset lo", lo, 32'h0);
    reset  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("mid-op reset no done", 32'(n_done), 32'd0);

    run_op("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
